// File: rtl/conv_acc_mmio.sv
// conv_acc_mmio: memory-mapped 1-D convolution accelerator on the EXT bus.
// The CPU loads coefficients, input samples, LEN and SHIFT, then writes start.
// A single MAC walks every valid output position, one product per cycle.
// Optional feature: define CONV_ACC_RELU_EN to clamp negative results to zero.
module conv_acc_mmio #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned AWIDTH = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic              en,
  input  logic              we,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              done
);

  localparam int unsigned IW    = AWIDTH - 2;
  localparam int unsigned DEPTH = 1 << IW;
  localparam int unsigned LW    = AWIDTH - 1;
  localparam int unsigned KW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int unsigned PW    = 2 * DATA_W;

  typedef enum logic [1:0] {StIdle, StMac, StStore, StFin} state_e;

  state_e                   state_q, state_d;
  logic [LW-1:0]            len_q;
  logic [4:0]               shift_q;
  logic signed [DATA_W-1:0] coef_q [KSIZE];
  logic signed [DATA_W-1:0] in_mem [DEPTH];
  logic signed [ACC_W-1:0]  out_mem [DEPTH];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [KW-1:0]            k_q, k_d;
  logic [LW-1:0]            i_q, i_d;
  logic                     done_q, done_d;
  logic                     out_we;

  // Bus decode
  logic [1:0]    region;
  logic [IW-1:0] low;
  logic [IW-1:0] coef_off;
  logic          wr, rd, busy, reg_wr, ctrl_wr, coef_hit, in_we, start;
  logic          unused_din;

  assign region   = addr[AWIDTH-1 -: 2];
  assign low      = addr[IW-1:0];
  assign coef_off = low - IW'(8);
  assign coef_hit = (low >= IW'(8)) && (coef_off < IW'(KSIZE));
  assign wr       = en & we;
  assign rd       = en & ~we;
  assign busy     = (state_q != StIdle);
  assign reg_wr   = wr && (region == 2'b00);
  assign ctrl_wr  = reg_wr && (low == IW'(0));
  assign in_we    = wr && (region == 2'b01) && !busy;
  assign start    = ctrl_wr && din[0] && !busy;
  // Upper data bits are intentionally ignored
  assign unused_din = ^din;

  // Output count M, zero when the input is shorter than the kernel
  logic [LW-1:0] m_val;
  assign m_val = (len_q >= LW'(KSIZE)) ? (len_q - LW'(KSIZE - 1)) : '0;

  // Datapath: sample index, product, shifted/clamped result
  logic [LW-1:0]           sum_idx;
  logic [IW-1:0]           samp_idx;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext, shifted, result;

  assign sum_idx  = i_q + LW'(k_q);
  assign samp_idx = sum_idx[IW-1:0];
  assign prod     = in_mem[samp_idx] * coef_q[k_q];
  assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
  assign shifted  = acc_q >>> shift_q;
`ifdef CONV_ACC_RELU_EN
  assign result = shifted[ACC_W-1] ? '0 : shifted;
`else
  assign result = shifted;
`endif

  // Next-state logic for the sequencer and accumulator
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    i_d     = i_q;
    done_d  = done_q;
    out_we  = 1'b0;
    if (ctrl_wr && din[1]) done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          acc_d   = '0;
          k_d     = '0;
          i_d     = '0;
          state_d = (m_val != '0) ? StMac : StFin;
        end
      end
      StMac: begin
        acc_d = acc_q + prod_ext;
        if (k_q == KW'(KSIZE - 1)) state_d = StStore;
        else                       k_d = k_q + KW'(1);
      end
      StStore: begin
        out_we = 1'b1;
        acc_d  = '0;
        k_d    = '0;
        if (i_q == m_val - LW'(1)) begin
          state_d = StFin;
        end else begin
          i_d     = i_q + LW'(1);
          state_d = StMac;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read mux; samples, coefficients and results are sign-extended
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    unique case (region)
      2'b00: begin
        if (low == IW'(0))      rdata = {30'b0, done_q, busy};
        else if (low == IW'(1)) rdata = 32'(len_q);
        else if (low == IW'(2)) rdata = 32'(shift_q);
        else if (coef_hit)      rdata = 32'(coef_q[coef_off[KW-1:0]]);
      end
      2'b01:   rdata = 32'(in_mem[low]);
      2'b10:   rdata = 32'(out_mem[low]);
      default: rdata = '0;
    endcase
  end

  // Control/config registers, sequencer state and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
      dout    <= '0;
      for (int k = 0; k < KSIZE; k++) coef_q[k] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      i_q     <= i_d;
      done_q  <= done_d;
      if (rd) dout <= rdata;
      if (reg_wr && !busy) begin
        if (low == IW'(1)) len_q <= din[LW-1:0];
        if (low == IW'(2)) shift_q <= din[4:0];
        if (coef_hit) coef_q[coef_off[KW-1:0]] <= din[DATA_W-1:0];
      end
    end
  end

  // Sample and result buffers, not reset
  always_ff @(posedge clk) begin
    if (in_we)  in_mem[low] <= din[DATA_W-1:0];
    if (out_we) out_mem[i_q[IW-1:0]] <= result;
  end

  assign done = done_q;

endmodule

// File: tb/tb_conv_acc_mmio.sv
// Directed bench for conv_acc_mmio with default parameters (KSIZE=3, AWIDTH=7).
module tb_conv_acc_mmio;
  logic        clk = 1'b0;
  logic        rst, en, we;
  logic [6:0]  addr;
  logic [31:0] din, dout;
  logic        done;
  int          errors = 0;
  int          checks = 0;
  int          cnt;
  logic [31:0] v;
  logic [31:0] neg_exp;

  always #5 clk = ~clk;

  conv_acc_mmio dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .en   (en),
    .we   (we),
    .din  (din),
    .dout (dout),
    .done (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [31:0] d);
    addr = a; we = 1'b0; en = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    d = dout;
  endtask

  // Poll CTRL every cycle; count reads showing busy, stop at first idle read
  task automatic busy_len(output int n, output logic [31:0] last);
    n = 0;
    rd(7'h00, last);
    while (last[0] && n < 200) begin
      n++;
      rd(7'h00, last);
    end
  endtask

  task automatic load3(input logic [31:0] c0, c1, c2);
    wr(7'h08, c0); wr(7'h09, c1); wr(7'h0A, c2);
  endtask

  initial begin
`ifdef CONV_ACC_RELU_EN
    neg_exp = 32'h0;
`else
    neg_exp = 32'hFFFF_FFFE;
`endif
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_dout", dout, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    rd(7'h00, v); check("reset_ctrl", v, 32'h0);
    rd(7'h01, v); check("reset_len", v, 32'h0);
    rd(7'h02, v); check("reset_shift", v, 32'h0);
    rd(7'h08, v); check("reset_coef0", v, 32'h0);

    // Run A: N=6 gives four outputs, so out[3] gets a known value
    load3(1, 2, 1);
    for (int i = 0; i < 6; i++) wr(7'h20 + 7'(i), 32'(i + 1));
    wr(7'h01, 6); wr(7'h02, 0);
    wr(7'h00, 1);
    busy_len(cnt, v);
    check("a_busy_len", 32'(cnt), 32'd17);
    check("a_ctrl_done", v, 32'h2);
    rd(7'h43, v); check("a_out3", v, 32'd20);

    // Run B: basic convolution N=5
    wr(7'h01, 5);
    wr(7'h00, 1);
    busy_len(cnt, v);
    check("b_busy_len", 32'(cnt), 32'd13);
    check("b_done_port", {31'b0, done}, 32'h1);
    rd(7'h40, v); check("b_out0", v, 32'd8);
    rd(7'h41, v); check("b_out1", v, 32'd12);
    rd(7'h42, v); check("b_out2", v, 32'd16);
    rd(7'h43, v); check("b_out3_kept", v, 32'd20);
    // dout holds while no read is issued
    repeat (3) @(posedge clk);
    #1 check("dout_hold", dout, 32'd20);

    // Run C: SHIFT=2
    wr(7'h02, 2);
    wr(7'h00, 1);
    busy_len(cnt, v);
    rd(7'h40, v); check("c_out0", v, 32'd2);
    rd(7'h41, v); check("c_out1", v, 32'd3);
    rd(7'h42, v); check("c_out2", v, 32'd4);

    // Run D: negative results
    load3(1, 0, 32'hFFFF_FFFF);
    wr(7'h02, 0); wr(7'h01, 4);
    rd(7'h0A, v); check("coef_signext", v, 32'hFFFF_FFFF);
    wr(7'h00, 1);
    busy_len(cnt, v);
    check("d_busy_len", 32'(cnt), 32'd9);
    rd(7'h40, v); check("d_out0", v, neg_exp);
    rd(7'h41, v); check("d_out1", v, neg_exp);
    rd(7'h42, v); check("d_out2_kept", v, 32'd4);

    // Run E: writes and restart during a run are ignored
    load3(1, 2, 1);
    wr(7'h01, 5);
    wr(7'h00, 1);
    wr(7'h08, 7); wr(7'h20, 9); wr(7'h00, 1);
    busy_len(cnt, v);
    check("e_busy_len", 32'(cnt), 32'd10);
    repeat (20) @(posedge clk);
    rd(7'h00, v); check("e_no_rerun", v, 32'h2);
    rd(7'h08, v); check("e_coef0_kept", v, 32'd1);
    rd(7'h20, v); check("e_in0_kept", v, 32'd1);
    rd(7'h40, v); check("e_out0", v, 32'd8);
    rd(7'h42, v); check("e_out2", v, 32'd16);

    // Run F: N < KSIZE, no outputs
    wr(7'h01, 2);
    wr(7'h00, 1);
    busy_len(cnt, v);
    check("f_busy_len", 32'(cnt), 32'd1);
    check("f_ctrl_done", v, 32'h2);
    rd(7'h40, v); check("f_out0_kept", v, 32'd8);
    rd(7'h43, v); check("f_out3_kept", v, 32'd20);
    wr(7'h00, 2);
    rd(7'h00, v); check("f_clear_done", v, 32'h0);
    check("f_done_port", {31'b0, done}, 32'h0);

    // Reserved region
    wr(7'h60, 32'h1234);
    rd(7'h60, v); check("reserved_zero", v, 32'h0);

    // Run G: start+clear together starts; reset aborts during MAC
    wr(7'h01, 5);
    wr(7'h00, 3);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("g_dout_reset", dout, 32'h0);
    check("g_done_reset", {31'b0, done}, 32'h0);
    rd(7'h00, v); check("g_ctrl_reset", v, 32'h0);
    rd(7'h01, v); check("g_len_reset", v, 32'h0);
    load3(1, 2, 1);
    for (int i = 0; i < 5; i++) wr(7'h20 + 7'(i), 32'(i + 1));
    wr(7'h01, 5); wr(7'h02, 1);
    wr(7'h00, 1);
    busy_len(cnt, v);
    check("g_busy_len", 32'(cnt), 32'd13);
    rd(7'h40, v); check("g_out0", v, 32'd4);
    rd(7'h41, v); check("g_out1", v, 32'd6);
    rd(7'h42, v); check("g_out2", v, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_acc_mmio.md
# conv_acc_mmio

Parametrised memory-mapped 1-D convolution accelerator; next generation of the fixed single-kernel convolution engine on the CPU's external (EXT_*) bus. The CPU loads a kernel, an input vector, a length and an output shift, then starts the engine. A sequential single-MAC datapath computes all valid outputs into an output buffer. A busy/done status register and a `done` level output report completion.

## Interface
- `DATA_W`, 8: signed width of samples and coefficients, 2..16.
- `KSIZE`, 3: kernel taps, 1..8.
- `ACC_W`, 32: signed accumulator and result width, 2*DATA_W+3..32.
- `AWIDTH`, 7: word-address width; buffer depth `DEPTH` = 2^(AWIDTH-2).
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  AWIDTH  word address within the block.
- `en`  in  1  access strobe, qualified by the top-level decode.
- `we`  in  1  write when `en`=1; read when `en`=1 and `we`=0.
- `din`  in  32  write data.
- `dout`  out  32  registered read data.
- `done`  out  1  mirrors the CTRL done bit.

## Operation
- Region select is `addr[AWIDTH-1:AWIDTH-2]`:
  - 00: registers.
  - 01: input buffer, `in[addr low bits]`.
  - 10: output buffer, `out[...]`, read-only.
  - 11: reserved; reads return 0, writes are ignored.
- Register offsets in region 00:
  - 0x00 CTRL. Write: bit0 = start, bit1 = clear done. Read: bit0 = busy, bit1 = done.
  - 0x01 LEN = N, bits [AWIDTH-3:0]+1 wide; 0 means no outputs.
  - 0x02 SHIFT, bits [4:0].
  - 0x08..0x08+KSIZE-1 = `coef[k]`.
  - Other offsets read 0.
- Samples and coefficients take `din[DATA_W-1:0]`, interpreted as signed. Reads return them sign-extended to 32 bits.
- Output count M = N-KSIZE+1 when N≥KSIZE, otherwise M = 0.
- `out[i]` = (Σk in[i+k]·coef[k]) >>> SHIFT.
  - Signed arithmetic, accumulated modulo 2^ACC_W.
  - Stored as ACC_W bits, read sign-extended to 32.
- FSM states: IDLE, MAC, STORE, FIN.
  - IDLE→MAC on a start write when M>0.
  - IDLE→FIN on a start write when M=0.
  - MAC runs k = 0..KSIZE-1, one product per cycle, then goes to STORE.
  - STORE writes `out[i]` and clears the accumulator. It goes to MAC if i<M-1, otherwise to FIN.
  - FIN sets done and returns to IDLE.
- A start write clears done. If start and clear-done are written together, the start takes effect.
- While busy (any state other than IDLE):
  - Writes to LEN, SHIFT, coefficients and the input buffer are ignored.
  - Start is ignored; clear-done still takes effect.
  - Reads are always serviced. An output-buffer read returns current contents, including entries not yet rewritten.
- Output entries with index ≥M keep their previous values.
- Reset effects:
  - FSM returns to IDLE; busy = 0, done = 0.
  - LEN, SHIFT, coefficients and `dout` are cleared to 0.
  - Input and output buffers are not cleared; their contents are don't-care after reset.
  - Reset mid-run aborts the run; no further output writes occur.

## Timing
- Read latency is 1 cycle: `dout` updates on the clock edge after `en`=1, `we`=0, and holds its value otherwise.
- A write takes effect at the clock edge where `en`=1 and `we`=1.
- Start written at edge t: busy reads 1 from t+1.
- Busy lasts M·(KSIZE+1)+1 cycles, or 1 cycle when M=0.
- Done and `done` rise in the same cycle that busy falls.
- `out[i]` is readable from the cycle after its STORE.

## Configuration
- `CONV_ACC_RELU_EN` defined: after the shift, results < 0 are stored as 0 (ReLU).
- Undefined: the signed shifted result is stored unchanged.

## Test plan
- Basic convolution, KSIZE=3: coef {1,2,1}, in {1,2,3,4,5}, N=5, SHIFT=0, start.
  - busy is high for exactly 13 cycles.
  - out[0..2] = 8, 12, 16; `done`=1.
  - out[3] is unchanged.
- Shift: same data with SHIFT=2 → out = 2, 3, 4.
- Negative results: coef {1,0,-1}, in {1,2,3,4}, N=4.
  - Without the macro: out[0..1] = 0xFFFFFFFE.
  - With `CONV_ACC_RELU_EN`: out[0..1] = 0.
- Busy guard: during a run, write coef[0]=7, in[0]=9, and start again.
  - coef[0] and in[0] read back their old values.
  - Results are unchanged; busy length is unchanged; no second run occurs.
- Short input: N=2 < KSIZE=3, start.
  - busy is high for 1 cycle, then done=1.
  - The output buffer is untouched.
  - A write of CTRL=0x2 clears done to 0.
- Reset mid-run: assert `rst` for 1 cycle during MAC.
  - Next cycle: busy=0, done=0, LEN=0, `dout`=0.
  - A fresh run after reloading the registers gives correct results.
